gate_eval_ctl: RTL
==================

// Module: gate_eval_ctl
// PURPOSE
// - Per-gate evaluation sequencer for the garbled-circuit evaluator. Sits between spi_decoder, label_ctl and aes.
// - Consumes decoded gate strobes; fetch results drive AND via AES plus ciphertext, XOR/BUF directly.
// - Emits one store request per gate. Successor to the inline top-level gate FSM: parametrised widths,
//   ciphertext buffering, early gate_id capture, timeout and coded sticky errors.
// PARAMETERS
// - LABEL_W  128  wire label / ciphertext width
// - ID_W     24   wire identifier width
// - NCTXT    4    ciphertext slots per AND gate (power of 2, <=4; index width IDX_W=2)
// - TIMEOUT  1024 max cycles in any wait state before abort
// - CNT_W    16   completed-gate counter width
// PORTS
// - clk            in   1        system clock
// - rst_n          in   1        synchronous reset, active low
// - gate_type      in   2        0=AND 1=XOR 2=BUF 3=reserved; valid with id strobes
// - id_1_strobe    in   1        first input id delivered
// - id_2_strobe    in   1        second input id delivered (AND/XOR only)
// - gate_id_strobe in   1        output wire id valid on gate_id
// - gate_id        in   ID_W     output wire id
// - ctxt_strobe    in   1        ciphertext valid on ctxt/ctxt_idx
// - ctxt           in   LABEL_W  garbled-table row
// - ctxt_idx       in   2        row index
// - fetch_done     in   1        label_ctl fetch complete; label_out/ctxt_point valid
// - label_out      in   LABEL_W  fetched (XOR-combined for 2-input) label
// - ctxt_point     in   2        point-and-permute row select
// - aes_start      out  1        one-cycle pulse: encrypt label_out
// - aes_done       in   1        aes_out valid
// - aes_out        in   LABEL_W  encryption result
// - store_strobe   out  1        one-cycle pulse: write new_label at store_id
// - store_id       out  ID_W     destination wire id
// - new_label      out  LABEL_W  computed output label
// - busy           out  1        state != IDLE
// - error          out  1        sticky error flag
// - err_code       out  2        1=reserved type 2=overrun 3=timeout; first error kept
// - err_clr        in   1        clears error/err_code
// - gate_count     out  CNT_W    gates stored; wraps at 2^CNT_W
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; ctxt valid bits, gid_pend, timer cleared. Reset mid-gate aborts, no store.
// - IDLE: id_1_strobe with BUF -> FETCH. id_2_strobe with AND/XOR -> FETCH. Type 3 on any id strobe -> err 1, stay IDLE.
//   Entering FETCH clears ctxt valid bits and gid_pend; ctxt/gate_id strobes in that cycle still captured.
// - FETCH: on fetch_done: AND -> aes_start=1 next cycle, latch ctxt_point, -> AES; XOR/BUF -> new_label<=label_out, -> WAIT_ID.
// - AES: on aes_done: if slot[ctxt_point] valid, new_label<=aes_out^slot, -> WAIT_ID; else -> CTXT.
//   Bypass: ctxt_strobe with ctxt_idx==ctxt_point in the aes_done cycle uses incoming ctxt directly.
// - CTXT: ctxt_strobe with ctxt_idx==ptr -> new_label<=aes_out_q^ctxt, -> WAIT_ID (aes_out registered at aes_done).
// - ctxt capture: any state but IDLE; ctxt_idx>=NCTXT ignored; repeat index overwrites.
// - gate_id: captured in any non-IDLE state (gid_pend=1); no error on early arrival.
// - WAIT_ID: if gid_pend or gate_id_strobe -> store_strobe=1 next cycle, store_id set, gate_count+1, -> IDLE.
//   new_label/store_id hold until next gate's result overwrites.
// - Overrun: id_1/id_2 strobe while busy -> err 2, strobe dropped, current gate continues.
// - Timeout: timer resets on every state change; reaching TIMEOUT in FETCH/AES/CTXT/WAIT_ID -> err 3, -> IDLE, no store.
// - Errors: error<=1, err_code set only if error was 0. New error same cycle as err_clr wins.
// - aes_start, store_strobe never high more than one consecutive cycle.
// STRUCTURE
// - Shared package gc_pkg: gate-type constants (AND/XOR/BUF/RSVD), error codes, state encoding.
// - Sub-module ctxt_buf: NCTXT x LABEL_W slots with valid bits, write port, clear, read-by-index with bypass.
// - FSM, timer, counter and error logic in gate_eval_ctl.
// TESTING
// - XOR: id_1,id_2 (type 1), fetch_done label=0xA5.., gate_id=7 -> one store_strobe, store_id=7, new_label=0xA5.., gate_count=1.
// - AND early ctxt: ctxt idx0..3 = C0..C3 before aes_done, ctxt_point=2, aes_out=K -> new_label=K^C2, one aes_start pulse.
// - AND late ctxt: aes_done first, then idx 1,3 (ptr=3) -> stays CTXT after idx1, stores K^C3 after idx3.
// - Early gate_id before fetch_done on BUF -> store 1 cycle after result, no error.
// - type 3 -> err_code=1; second id_2 while busy -> err stays 1 (first kept); err_clr -> 0.
// - fetch_done withheld TIMEOUT cycles -> err_code=3, busy=0, no store; rst_n low mid-AES -> all outputs 0.

Source files
------------

// File: rtl/gc_pkg.sv
// Shared constants for the garbled-circuit gate evaluator:
// gate types, error codes and sequencer state encoding.
package gc_pkg;

  localparam logic [1:0] GT_AND  = 2'd0;
  localparam logic [1:0] GT_XOR  = 2'd1;
  localparam logic [1:0] GT_BUF  = 2'd2;
  localparam logic [1:0] GT_RSVD = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_RSVD = 2'd1;
  localparam logic [1:0] ERR_OVR  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_AES,
    S_CTXT,
    S_WAIT_ID
  } state_e;

endpackage

// File: rtl/ctxt_buf.sv
// Garbled-table row buffer: NCTXT slots with valid bits,
// one write port, bulk clear and an index read with write bypass.
module ctxt_buf #(
  parameter int LABEL_W = 128,
  parameter int NCTXT   = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [LABEL_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic               rd_valid_o,
  output logic [LABEL_W-1:0] rd_data_o
);

  logic [LABEL_W-1:0] slot_q [NCTXT];
  logic [NCTXT-1:0]   valid_q;
  logic               wr_ok;
  logic               rd_ok;
  logic               byp;

  assign wr_ok = wr_en_i && (32'(wr_idx_i) < NCTXT);
  assign rd_ok = 32'(rd_idx_i) < NCTXT;
  assign byp   = wr_ok && (wr_idx_i == rd_idx_i);

  assign rd_valid_o = byp || (rd_ok && valid_q[rd_idx_i]);
  assign rd_data_o  = byp ? wr_data_i : slot_q[rd_idx_i];

  // a write in the clear cycle belongs to the new gate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (clr_i)
        valid_q <= '0;
      if (wr_ok)
        valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      slot_q[wr_idx_i] <= wr_data_i;
  end

endmodule

// File: rtl/gate_eval_ctl.sv
// Per-gate evaluation sequencer: fetch, optional AES + ciphertext,
// then one store per gate, with timeout and sticky coded errors.
module gate_eval_ctl
  import gc_pkg::*;
#(
  parameter int LABEL_W = 128,
  parameter int ID_W    = 24,
  parameter int NCTXT   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         gate_type,
  input  logic               id_1_strobe,
  input  logic               id_2_strobe,
  input  logic               gate_id_strobe,
  input  logic [ID_W-1:0]    gate_id,
  input  logic               ctxt_strobe,
  input  logic [LABEL_W-1:0] ctxt,
  input  logic [1:0]         ctxt_idx,
  input  logic               fetch_done,
  input  logic [LABEL_W-1:0] label_out,
  input  logic [1:0]         ctxt_point,
  output logic               aes_start,
  input  logic               aes_done,
  input  logic [LABEL_W-1:0] aes_out,
  output logic               store_strobe,
  output logic [ID_W-1:0]    store_id,
  output logic [LABEL_W-1:0] new_label,
  output logic               busy,
  output logic               error,
  output logic [1:0]         err_code,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   gate_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e             state_q;
  logic [1:0]         type_q;
  logic [1:0]         pt_q;
  logic [ID_W-1:0]    gid_q;
  logic               gid_pend_q;
  logic [LABEL_W-1:0] aes_q;
  logic [TW-1:0]      timer_q;
  logic               aes_start_q;
  logic               store_q;
  logic [ID_W-1:0]    store_id_q;
  logic [LABEL_W-1:0] label_q;
  logic               error_q;
  logic [1:0]         code_q;
  logic [CNT_W-1:0]   count_q;

  logic               idle;
  logic               start;
  logic               cap;
  logic               tmo;
  logic [1:0]         err_new;
  logic               rd_valid;
  logic [LABEL_W-1:0] rd_data;

  assign idle  = (state_q == S_IDLE);
  assign start = idle &&
    ((id_1_strobe && gate_type == GT_BUF) ||
     (id_2_strobe && (gate_type == GT_AND ||
                      gate_type == GT_XOR)));
  assign cap   = !idle || start;
  assign tmo   = !idle && (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    err_new = ERR_NONE;
    if (tmo)
      err_new = ERR_TMO;
    else if (!idle && (id_1_strobe || id_2_strobe))
      err_new = ERR_OVR;
    else if (idle && (id_1_strobe || id_2_strobe) &&
             gate_type == GT_RSVD)
      err_new = ERR_RSVD;
  end

  ctxt_buf #(
    .LABEL_W (LABEL_W),
    .NCTXT   (NCTXT),
    .IDX_W   (2)
  ) u_ctxt_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start),
    .wr_en_i    (ctxt_strobe && cap),
    .wr_idx_i   (ctxt_idx),
    .wr_data_i  (ctxt),
    .rd_idx_i   (pt_q),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      type_q      <= GT_AND;
      pt_q        <= '0;
      gid_q       <= '0;
      gid_pend_q  <= 1'b0;
      aes_q       <= '0;
      timer_q     <= '0;
      aes_start_q <= 1'b0;
      store_q     <= 1'b0;
      store_id_q  <= '0;
      label_q     <= '0;
      error_q     <= 1'b0;
      code_q      <= ERR_NONE;
      count_q     <= '0;
    end else begin
      aes_start_q <= 1'b0;
      store_q     <= 1'b0;
      timer_q     <= idle ? '0 : timer_q + 1'b1;

      if (cap && gate_id_strobe) begin
        gid_q      <= gate_id;
        gid_pend_q <= 1'b1;
      end else if (start) begin
        gid_pend_q <= 1'b0;
      end

      if (tmo) begin
        state_q <= S_IDLE;
        timer_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              type_q  <= gate_type;
              state_q <= S_FETCH;
              timer_q <= '0;
            end
          end
          S_FETCH: begin
            if (fetch_done) begin
              timer_q <= '0;
              if (type_q == GT_AND) begin
                aes_start_q <= 1'b1;
                pt_q        <= ctxt_point;
                state_q     <= S_AES;
              end else begin
                label_q <= label_out;
                state_q <= S_WAIT_ID;
              end
            end
          end
          S_AES: begin
            if (aes_done) begin
              timer_q <= '0;
              aes_q   <= aes_out;
              if (rd_valid) begin
                label_q <= aes_out ^ rd_data;
                state_q <= S_WAIT_ID;
              end else begin
                state_q <= S_CTXT;
              end
            end
          end
          S_CTXT: begin
            if (rd_valid) begin
              timer_q <= '0;
              label_q <= aes_q ^ rd_data;
              state_q <= S_WAIT_ID;
            end
          end
          S_WAIT_ID: begin
            if (gid_pend_q || gate_id_strobe) begin
              timer_q    <= '0;
              store_q    <= 1'b1;
              store_id_q <= gate_id_strobe ? gate_id : gid_q;
              count_q    <= count_q + 1'b1;
              state_q    <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end

      // a clear in the same cycle makes room for the new code
      if (err_new != ERR_NONE) begin
        error_q <= 1'b1;
        if (!error_q || err_clr)
          code_q <= err_new;
      end else if (err_clr) begin
        error_q <= 1'b0;
        code_q  <= ERR_NONE;
      end
    end
  end

  assign aes_start    = aes_start_q;
  assign store_strobe = store_q;
  assign store_id     = store_id_q;
  assign new_label    = label_q;
  assign busy         = !idle;
  assign error        = error_q;
  assign err_code     = code_q;
  assign gate_count   = count_q;

endmodule
